// File: rtl/mem_arbi_pkg.sv
// Encodings shared by the DDR read and write round-robin arbiters.
package mem_arbi_pkg;

   localparam int LEN_BITS = 10;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CHECK = 3'd1,
      ST_BEGIN = 3'd2,
      ST_READ  = 3'd3,
      ST_END   = 3'd4
   } arbi_state_e;

endpackage

// File: rtl/mem_read_arbi_rr_if.sv
// Burst-read channel bundle; N lanes of req/len/addr/valid/finish share one data bus.
interface mem_read_arbi_rr_if
   import mem_arbi_pkg::*;
#(
   parameter int N             = 1,
   parameter int ADDR_BITS     = 25,
   parameter int MEM_DATA_BITS = 32
);
   logic [N-1:0]             rd_burst_req;
   logic [N*LEN_BITS-1:0]    rd_burst_len;
   logic [N*ADDR_BITS-1:0]   rd_burst_addr;
   logic [N-1:0]             rd_burst_data_valid;
   logic [MEM_DATA_BITS-1:0] rd_burst_data;
   logic [N-1:0]             rd_burst_finish;

   modport master (
      output rd_burst_req, rd_burst_len, rd_burst_addr,
      input  rd_burst_data_valid, rd_burst_data, rd_burst_finish
   );

   modport slave (
      input  rd_burst_req, rd_burst_len, rd_burst_addr,
      output rd_burst_data_valid, rd_burst_data, rd_burst_finish
   );
endinterface

// File: rtl/mem_arbi_rr_ptr.sv
// Round-robin channel pointer, wraps after PORTS-1; shared with the write arbiter.
module mem_arbi_rr_ptr #(
   parameter int PORTS    = 8,
   parameter int PTR_BITS = (PORTS > 1) ? $clog2(PORTS) : 1
) (
   input  logic                mem_clk,
   input  logic                rst_n,
   input  logic                advance,
   output logic [PTR_BITS-1:0] ptr
);
   logic [PTR_BITS-1:0] ptr_r;

   // Step to the next channel on request, wrapping at the last one.
   always_ff @(posedge mem_clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_r <= '0;
      end else if (advance) begin
         if (ptr_r == PTR_BITS'(PORTS - 1)) begin
            ptr_r <= '0;
         end else begin
            ptr_r <= ptr_r + PTR_BITS'(1);
         end
      end
   end

   assign ptr = ptr_r;
endmodule

// File: rtl/mem_read_arbi_rr.sv
// Round-robin read arbiter: PORTS clients share one DDR burst-read port.
// Optional watchdog on a stalled burst: define MEM_RD_ARBI_WDOG_EN.
module mem_read_arbi_rr
   import mem_arbi_pkg::*;
#(
   parameter int MEM_DATA_BITS = 32,
   parameter int ADDR_BITS     = 25,
   parameter int PORTS         = 8,
   parameter int WDOG_LIMIT    = 8000
) (
   input logic               mem_clk,
   input logic               rst_n,
   mem_read_arbi_rr_if.slave  ch,
   mem_read_arbi_rr_if.master mem
);
   localparam int PTR_BITS = $clog2(PORTS);

   arbi_state_e              state_r, state_s;
   logic [PTR_BITS-1:0]      ptr_s;
   logic                     adv_s;
   logic                     grant_ok_s;
   logic                     wdog_exp_s;
   logic                     req_r;
   logic [LEN_BITS-1:0]      len_r;
   logic [ADDR_BITS-1:0]     addr_r;
   logic                     fin_d0_r, fin_d1_r;
   logic [PORTS-1:0]         valid_s, fin_s;
   logic [MEM_DATA_BITS-1:0] data_s;
   logic [LEN_BITS-1:0]      ch_len_s  [PORTS];
   logic [ADDR_BITS-1:0]     ch_addr_s [PORTS];

   if (PORTS < 2 || PORTS > 8 || WDOG_LIMIT < 1) begin : g_cfg_bad
      $error("mem_read_arbi_rr: PORTS must be 2..8 and WDOG_LIMIT positive");
   end

   for (genvar g = 0; g < PORTS; g++) begin : g_unpack
      assign ch_len_s[g]  = ch.rd_burst_len[g*LEN_BITS +: LEN_BITS];
      assign ch_addr_s[g] = ch.rd_burst_addr[g*ADDR_BITS +: ADDR_BITS];
   end

   mem_arbi_rr_ptr #(.PORTS(PORTS), .PTR_BITS(PTR_BITS)) u_ptr (
      .mem_clk (mem_clk),
      .rst_n   (rst_n),
      .advance (adv_s),
      .ptr     (ptr_s)
   );

   assign grant_ok_s = ch.rd_burst_req[ptr_s] && (ch_len_s[ptr_s] != {LEN_BITS{1'b0}});

   // State register.
   always_ff @(posedge mem_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next state and pointer advance; END always moves past the channel just served.
   always_comb begin
      state_s = state_r;
      adv_s   = 1'b0;
      case (state_r)
         ST_IDLE:  state_s = ST_CHECK;
         ST_CHECK: begin
            if (grant_ok_s) begin
               state_s = ST_BEGIN;
            end else begin
               adv_s = 1'b1;
            end
         end
         ST_BEGIN: state_s = ST_READ;
         ST_READ: begin
            if (fin_d1_r || wdog_exp_s) begin
               state_s = ST_END;
            end else begin
               state_s = ST_READ;
            end
         end
         ST_END: begin
            adv_s   = 1'b1;
            state_s = ST_CHECK;
         end
         default: state_s = ST_IDLE;
      endcase
   end

   // Controller request, latched burst parameters and finish delay line.
   always_ff @(posedge mem_clk or negedge rst_n) begin
      if (!rst_n) begin
         req_r    <= 1'b0;
         len_r    <= {LEN_BITS{1'b0}};
         addr_r   <= {ADDR_BITS{1'b0}};
         fin_d0_r <= 1'b0;
         fin_d1_r <= 1'b0;
      end else if (state_r == ST_BEGIN) begin
         req_r    <= 1'b1;
         len_r    <= ch_len_s[ptr_s];
         addr_r   <= ch_addr_s[ptr_s];
         fin_d0_r <= 1'b0;
         fin_d1_r <= 1'b0;
      end else begin
         fin_d0_r <= mem.rd_burst_finish[0];
         fin_d1_r <= fin_d0_r;
         if (wdog_exp_s || mem.rd_burst_data_valid[0] || mem.rd_burst_finish[0]) begin
            req_r <= 1'b0;
         end
      end
   end

`ifdef MEM_RD_ARBI_WDOG_EN
   logic [31:0] wdog_cnt_r;

   // Cycles spent on the current grant, restarted at BEGIN.
   always_ff @(posedge mem_clk or negedge rst_n) begin
      if (!rst_n) begin
         wdog_cnt_r <= 32'd0;
      end else if (state_r == ST_BEGIN) begin
         wdog_cnt_r <= 32'd0;
      end else if (state_r == ST_READ || state_r == ST_END) begin
         wdog_cnt_r <= wdog_cnt_r + 32'd1;
      end
   end

   assign wdog_exp_s = (state_r == ST_READ) && (wdog_cnt_r > 32'(WDOG_LIMIT));
`else
   assign wdog_exp_s = 1'b0;
`endif

   // Route beats and the finish pulse to the granted channel only.
   always_comb begin
      valid_s = {PORTS{1'b0}};
      fin_s   = {PORTS{1'b0}};
      if (state_r == ST_READ) begin
         valid_s[ptr_s] = mem.rd_burst_data_valid[0];
      end else if (state_r == ST_END) begin
         fin_s[ptr_s] = 1'b1;
      end else begin
         valid_s = {PORTS{1'b0}};
      end
   end

   assign data_s                 = mem.rd_burst_data;
   assign ch.rd_burst_data       = data_s;
   assign ch.rd_burst_data_valid = valid_s;
   assign ch.rd_burst_finish     = fin_s;
   assign mem.rd_burst_req[0]    = req_r;
   assign mem.rd_burst_len       = len_r;
   assign mem.rd_burst_addr      = addr_r;
endmodule
